// File: rtl/pipe_mux.sv
// pipe_mux: N-way data selector feeding a 2-entry FIFO, with out-of-range
// select detection and a saturating count of bad selections.
module pipe_mux #(
  parameter int MUX_BIT_WIDTH = 8,
  parameter int NUM_INPUTS    = 4,
  parameter int SEL_WIDTH     = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_INPUTS*MUX_BIT_WIDTH-1:0] data_in,
  input  logic [SEL_WIDTH-1:0]                sel,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [MUX_BIT_WIDTH-1:0]            data_out,
  output logic                                sel_err,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [7:0]                          err_count
);

  // One extra bit so NUM_INPUTS == 2**SEL_WIDTH still compares correctly.
  localparam logic [SEL_WIDTH:0] NUM_IN_L = (SEL_WIDTH+1)'(NUM_INPUTS);

  logic [MUX_BIT_WIDTH-1:0] mem_data_r [2];
  logic [1:0]               mem_err_r;
  logic                     wr_ptr_r;
  logic                     rd_ptr_r;
  logic [1:0]               count_r;
  logic [7:0]               err_count_r;

  logic                     push_s;
  logic                     pop_s;
  logic                     range_err_s;
  logic [MUX_BIT_WIDTH-1:0] sel_data_s;

  // Select the addressed input and flag indices with no corresponding input.
  always_comb begin
    sel_data_s = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (sel == SEL_WIDTH'(k)) begin
        sel_data_s = data_in[k*MUX_BIT_WIDTH +: MUX_BIT_WIDTH];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
    range_err_s = ({1'b0, sel} >= NUM_IN_L);
  end

  // Handshake and head-of-queue presentation from registered state.
  always_comb begin
    in_ready  = (count_r < 2'd2) & ~rst;
    out_valid = (count_r != 2'd0);
    push_s    = in_valid & in_ready;
    pop_s     = out_valid & out_ready;
    err_count = err_count_r;
    if (out_valid) begin
      data_out = mem_data_r[rd_ptr_r];
      sel_err  = mem_err_r[rd_ptr_r];
    end else begin
      data_out = '0;
      sel_err  = 1'b0;
    end
  end

  // FIFO storage, pointers, occupancy and error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_data_r[i] <= '0;
      end
      mem_err_r   <= 2'b00;
      wr_ptr_r    <= 1'b0;
      rd_ptr_r    <= 1'b0;
      count_r     <= 2'd0;
      err_count_r <= 8'd0;
    end else begin
      if (push_s) begin
        mem_data_r[wr_ptr_r] <= range_err_s ? '0 : sel_data_s;
        mem_err_r[wr_ptr_r]  <= range_err_s;
        wr_ptr_r             <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
      if (push_s && range_err_s && (err_count_r != 8'hFF)) begin
        err_count_r <= err_count_r + 8'd1;
      end
    end
  end

endmodule
